fp32_adder: RTL and testbench
=============================

Name:
fp32_adder

Overview:
- Multi-cycle IEEE-754 binary32 adder built around a fixed-latency state machine.
- Each add is launched by releasing reset: operands are sampled, the sum is computed, then `done` is raised and the result is held.
- Used as the floating-point add unit inside the FPU datapath.
- Handles subnormals, signed zeros, infinities and NaN; rounding is round-to-nearest-even only.

Parameters:
- None. Widths are fixed by binary32: 1 sign bit, 8 exponent bits, 23 fraction bits.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset. Low clears the unit; the low-to-high transition starts an operation.
- Xin  input  32  operand X, binary32.
- Yin  input  32  operand Y, binary32.
- Zout  output  32  X+Y, binary32, valid while done=1.
- done  output  1  high when Zout holds the finished result.

Behaviour:
- Reset low: asynchronously force state=LOAD, Zout=0x00000000, done=0, and clear all internal registers.
- Xin and Yin must be stable from reset deassertion through the LOAD edge.
- The FSM advances one state per rising edge after reset goes high:
  - LOAD: register Xin and Yin.
  - UNPACK: split sign, exponent and fraction. Exp=0 gives hidden bit 0 and effective exponent 1 (subnormal); otherwise hidden bit 1. Classify NaN, Inf and zero.
  - ALIGN: order operands by magnitude. Barrel-shift the smaller significand right by the exponent difference into a 27-bit {sig, guard, round, sticky} field. The sticky bit is the OR of all shifted-out bits; a difference >26 collapses the smaller operand to sticky only.
  - ADD: signs equal gives a magnitude add; otherwise larger minus smaller. Result sign is the sign of the larger magnitude.
  - NORM: on carry-out, shift right 1 and increment the exponent, keeping sticky. Otherwise shift left by the leading-zero count, limited so the exponent does not go below 1. If the hidden bit is still 0 at exponent 1, the result is subnormal and the stored exponent is 0.
  - ROUND: round to nearest, ties to even, using guard/round/sticky. A rounding carry renormalises, and a subnormal can round up to the minimum normal. Exponent ≥255 gives ±Inf.
  - PACK: assemble Zout.
  - DONE: done=1; Zout and done hold until the next reset assertion.
- Latency: done rises on the 7th rising clk edge after reset deasserts. The unit never takes more than 8 cycles.
- Special cases (resolved in UNPACK, carried to PACK):
  - Any NaN input → 0x7FC00000.
  - +Inf + -Inf → 0x7FC00000.
  - Inf + finite → that Inf.
  - Exact-zero sum of opposite-sign operands → +0.
  - (+0)+(+0) → +0.
  - (-0)+(-0) → -0.
- No exception flags are produced.
- Reset asserted mid-operation aborts immediately to the reset values; there is no partial result.
- Input changes after LOAD are ignored.

Decomposition:
- Shared package fp32_pkg holds:
  - field widths (EXP_W=8, FRAC_W=23, BIAS=127);
  - constants QNAN=32'h7FC00000, POS_INF=32'h7F800000;
  - the FSM state enum.
- One natural sub-module, fp32_lzc: a 27-bit leading-zero counter used in NORM.
- Everything else stays in fp32_adder.

Test Plan:
- Xin=0x3F4CCCCD (0.8), Yin=0xBF333333 (-0.7), release reset → done at edge 7, Zout=0x3DCCCCD0. Swapping the operands gives the same result.
- Xin=0xBF4CCCCD (-0.8), Yin=0x3F333333 (0.7) → Zout=0xBDCCCCD0. Swapping the operands gives the same result.
- Xin=0x007FFFFF, Yin=0x00000001 (subnormal+subnormal) → Zout=0x00800000. Swapping the operands gives the same result.
- Xin=0x00800000, Yin=0x80000001 → Zout=0x007FFFFF. Xin=0x00800000, Yin=0x81000001 → Zout=0x80800002.
- Specials:
  - 0x7F800000+0xFF800000 → 0x7FC00000.
  - 0x3F800000+0xBF800000 → 0x00000000.
  - 0x7F7FFFFF+0x7F7FFFFF → 0x7F800000.
  - 0x7FC00001+0x3F800000 → 0x7FC00000.
- Reset pulled low at cycle 3 of an operation → done=0 and Zout=0 immediately. A new operation after release completes at edge 7; done stays high and Zout stays stable for at least 50 cycles with the inputs toggling.

Source files
------------

// File: rtl/fp32_pkg.sv
// Shared binary32 constants and adder state encoding.
// The state type is a plain 3-bit vector so checkers and older tools can decode it.
package fp32_pkg;
   localparam int EXP_W  = 8;
   localparam int FRAC_W = 23;
   localparam int BIAS   = 127;

   localparam logic [31:0] QNAN    = 32'h7FC0_0000;
   localparam logic [31:0] POS_INF = 32'h7F80_0000;

   typedef logic [2:0] state_t;

   localparam state_t S_LOAD   = 3'd0;
   localparam state_t S_UNPACK = 3'd1;
   localparam state_t S_ALIGN  = 3'd2;
   localparam state_t S_ADD    = 3'd3;
   localparam state_t S_NORM   = 3'd4;
   localparam state_t S_ROUND  = 3'd5;
   localparam state_t S_PACK   = 3'd6;
   localparam state_t S_DONE   = 3'd7;
endpackage

// File: rtl/fp32_lzc.sv
// Leading-zero counter over the 27-bit {sig, guard, round, sticky} field.
// An all-zero input reports 27.
module fp32_lzc (
   input  logic [26:0] value,
   output logic [4:0]  count
);
   always_comb begin
      count = 5'd27;
      for (int i = 0; i < 27; i++) begin
         if (value[i]) count = 5'(26 - i);
      end
   end
endmodule

// File: rtl/fp32_adder.sv
// Fixed-latency binary32 adder: releasing reset runs LOAD..PACK, then holds the sum.
// Round-to-nearest-even; NaN/Inf outcomes are resolved early and override the datapath.
module fp32_adder
   import fp32_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] Xin,
   input  logic [31:0] Yin,
   output logic [31:0] Zout,
   output logic        done,
   output state_t      dbg_state
);
   state_t      state;
   logic [31:0] x_q, y_q;
   logic        sx, sy, sgn, sub, special;
   logic [7:0]  ex, ey;
   logic [23:0] mx, my;
   logic [31:0] special_val;
   logic [9:0]  exp_r;
   logic [26:0] al, sm, nm;
   logic [27:0] sum;
   logic [22:0] frac_r;

   assign dbg_state = state;

   // Combinational views of each stage's next values.
   logic        x_nan, y_nan, x_inf, y_inf, x_big;
   logic [7:0]  big_e, small_e, diff;
   logic [23:0] big_m, small_m;
   logic [52:0] wide;
   logic [26:0] sm_n, nm_n;
   logic [27:0] sum_n;
   logic [4:0]  lz;
   logic [9:0]  lim, sh, exp_norm, exp_rnd;
   logic [24:0] rs;
   logic        up;
   logic [22:0] frac_n;

   fp32_lzc u_lzc (.value(sum[26:0]), .count(lz));

   always_comb begin
      x_nan   = (x_q[30:23] == 8'hFF) && (x_q[22:0] != 23'd0);
      y_nan   = (y_q[30:23] == 8'hFF) && (y_q[22:0] != 23'd0);
      x_inf   = (x_q[30:23] == 8'hFF) && (x_q[22:0] == 23'd0);
      y_inf   = (y_q[30:23] == 8'hFF) && (y_q[22:0] == 23'd0);

      x_big   = {ex, mx} >= {ey, my};
      big_e   = x_big ? ex : ey;
      big_m   = x_big ? mx : my;
      small_e = x_big ? ey : ex;
      small_m = x_big ? my : mx;
      diff    = big_e - small_e;
      wide    = {small_m, 29'd0} >> diff;
      if (diff > 8'd26) sm_n = {26'd0, |small_m};
      else              sm_n = {wide[52:27], wide[26] | (|wide[25:0])};

      sum_n = sub ? ({1'b0, al} - {1'b0, sm}) : ({1'b0, al} + {1'b0, sm});

      // Left shift stops at exponent 1; a missing hidden bit there means subnormal.
      lim = exp_r - 10'd1;
      sh  = ({5'd0, lz} > lim) ? lim : {5'd0, lz};
      if (sum[27]) begin
         nm_n     = {sum[27:2], sum[1] | sum[0]};
         exp_norm = exp_r + 10'd1;
      end else begin
         nm_n     = sum[26:0] << sh;
         exp_norm = nm_n[26] ? (exp_r - sh) : 10'd0;
      end

      up      = nm[2] & (nm[1] | nm[0] | nm[3]);
      rs      = {1'b0, nm[26:3]} + {24'd0, up};
      exp_rnd = exp_r;
      if (rs[24])                            exp_rnd = exp_r + 10'd1;
      else if ((exp_r == 10'd0) && rs[23])   exp_rnd = 10'd1;
      frac_n  = rs[24] ? rs[23:1] : rs[22:0];
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state       <= S_LOAD;
         Zout        <= 32'd0;
         done        <= 1'b0;
         x_q         <= 32'd0;
         y_q         <= 32'd0;
         sx          <= 1'b0;
         sy          <= 1'b0;
         ex          <= 8'd0;
         ey          <= 8'd0;
         mx          <= 24'd0;
         my          <= 24'd0;
         special     <= 1'b0;
         special_val <= 32'd0;
         sgn         <= 1'b0;
         sub         <= 1'b0;
         exp_r       <= 10'd0;
         al          <= 27'd0;
         sm          <= 27'd0;
         sum         <= 28'd0;
         nm          <= 27'd0;
         frac_r      <= 23'd0;
      end else begin
         case (state)
            S_LOAD: begin
               x_q   <= Xin;
               y_q   <= Yin;
               state <= S_UNPACK;
            end
            S_UNPACK: begin
               sx <= x_q[31];
               sy <= y_q[31];
               ex <= (x_q[30:23] == 8'd0) ? 8'd1 : x_q[30:23];
               ey <= (y_q[30:23] == 8'd0) ? 8'd1 : y_q[30:23];
               mx <= {x_q[30:23] != 8'd0, x_q[22:0]};
               my <= {y_q[30:23] != 8'd0, y_q[22:0]};
               special <= x_nan | y_nan | x_inf | y_inf;
               if (x_nan || y_nan || (x_inf && y_inf && (x_q[31] != y_q[31])))
                  special_val <= QNAN;
               else if (x_inf)
                  special_val <= x_q;
               else
                  special_val <= y_q;
               state <= S_ALIGN;
            end
            S_ALIGN: begin
               al    <= {big_m, 3'b000};
               sm    <= sm_n;
               exp_r <= {2'b00, big_e};
               sgn   <= x_big ? sx : sy;
               sub   <= sx != sy;
               state <= S_ADD;
            end
            S_ADD: begin
               sum <= sum_n;
               if (sub && (sum_n == 28'd0)) sgn <= 1'b0;
               state <= S_NORM;
            end
            S_NORM: begin
               nm    <= nm_n;
               exp_r <= exp_norm;
               state <= S_ROUND;
            end
            S_ROUND: begin
               exp_r  <= exp_rnd;
               frac_r <= frac_n;
               if (!special && (exp_rnd >= 10'd255)) begin
                  special     <= 1'b1;
                  special_val <= {sgn, POS_INF[30:0]};
               end
               state <= S_PACK;
            end
            S_PACK: begin
               Zout  <= special ? special_val : {sgn, exp_r[7:0], frac_r};
               done  <= 1'b1;
               state <= S_DONE;
            end
            default: state <= S_DONE;
         endcase
      end
   end
endmodule

// File: tb/tb_fp32_adder.sv
// Bench for fp32_adder: directed cases, randomized operands against an exact
// big-integer reference, async abort and result-hold behaviour.
module tb_fp32_adder;
   import fp32_pkg::*;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic [31:0] Xin = 32'd0;
   logic [31:0] Yin = 32'd0;
   logic [31:0] Zout;
   logic        done;
   state_t      dbg_state;

   int errors = 0;
   int checks = 0;
   logic [31:0] exp_q[$];

   fp32_adder dut (
      .clk(clk), .reset(reset), .Xin(Xin), .Yin(Yin),
      .Zout(Zout), .done(done), .dbg_state(dbg_state)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s: got=%08h expected=%08h", tag, got, want);
      end
   endtask

   // Magnitude in units of 2^-149, the smallest subnormal.
   function automatic logic [299:0] mag_of(input logic [31:0] v);
      logic [299:0] m;
      if (v[30:23] == 8'd0) m = {277'd0, v[22:0]};
      else                  m = {276'd0, 1'b1, v[22:0]} << (v[30:23] - 8'd1);
      return m;
   endfunction

   function automatic logic [31:0] ref_add(input logic [31:0] x, input logic [31:0] y);
      logic         xn, yn, xi, yi, s;
      logic [299:0] a, b, mag, q, rem, half, one;
      int           p, k;
      xn = (x[30:23] == 8'hFF) && (x[22:0] != 0);
      yn = (y[30:23] == 8'hFF) && (y[22:0] != 0);
      xi = (x[30:23] == 8'hFF) && (x[22:0] == 0);
      yi = (y[30:23] == 8'hFF) && (y[22:0] == 0);
      if (xn || yn) return 32'h7FC0_0000;
      if (xi && yi) return (x[31] != y[31]) ? 32'h7FC0_0000 : x;
      if (xi) return x;
      if (yi) return y;
      a = mag_of(x);
      b = mag_of(y);
      if (x[31] == y[31]) begin mag = a + b; s = x[31]; end
      else if (a >= b)    begin mag = a - b; s = x[31]; end
      else                begin mag = b - a; s = y[31]; end
      if (mag == 0) return {x[31] & y[31], 31'd0};
      if (mag < 300'd16777216) return {s, mag[30:0]};
      p = 0;
      for (int i = 0; i < 300; i++) if (mag[i]) p = i;
      k    = p - 23;
      one  = 300'd1;
      q    = mag >> k;
      rem  = mag & ((one << k) - one);
      half = one << (k - 1);
      if ((rem > half) || ((rem == half) && q[0])) q = q + one;
      if (q[24]) begin q = q >> 1; k++; end
      if (k + 1 >= 255) return {s, 8'hFF, 23'd0};
      return {s, 8'(k + 1), q[22:0]};
   endfunction

   function automatic logic [31:0] rand_fp(input logic [31:0] other);
      logic [31:0] v;
      v = $urandom;
      case ($urandom_range(0, 5))
         1: v = {1'($urandom_range(0, 1)), 8'd0, 23'($urandom)};
         2: v = {1'($urandom_range(0, 1)), 8'($urandom_range(1, 3)), 23'($urandom)};
         3: case ($urandom_range(0, 3))
               0: v = {1'($urandom_range(0, 1)), 31'd0};
               1: v = {1'($urandom_range(0, 1)), 8'hFF, 23'd0};
               2: v = {1'($urandom_range(0, 1)), 8'hFF, 23'($urandom_range(1, 8388607))};
               default: v = {1'($urandom_range(0, 1)), 8'hFE, 23'h7FFFFF};
            endcase
         4: v = {~other[31], other[30:23], other[22:0] ^ 23'($urandom_range(0, 7))};
         5: v = {1'($urandom_range(0, 1)), other[30:23] - 8'($urandom_range(0, 30)), 23'($urandom)};
         default: v = $urandom;
      endcase
      return v;
   endfunction

   // Wait up to 10 edges for done; returns the edge number it appeared on (10 if never).
   task automatic wait_done(output int n, input bit scramble);
      n = 0;
      while (n < 10 && !done) begin
         @(posedge clk);
         #1;
         n++;
         if (scramble) begin Xin = $urandom; Yin = $urandom; end
      end
   endtask

   task automatic run_op(input string tag, input logic [31:0] x, input logic [31:0] y,
                         input logic [31:0] want);
      int n;
      @(negedge clk);
      reset = 1'b0;
      Xin = x;
      Yin = y;
      exp_q.push_back(want);
      #1;
      check({tag, "_rst_done"}, {31'd0, done}, 32'd0);
      check({tag, "_rst_z"}, Zout, 32'd0);
      @(negedge clk);
      reset = 1'b1;
      wait_done(n, 1'b1);
      check({tag, "_lat"}, n, 32'd7);
      check({tag, "_z"}, Zout, exp_q.pop_front());
   endtask

   task automatic run_pair(input string tag, input logic [31:0] x, input logic [31:0] y,
                           input logic [31:0] want);
      run_op(tag, x, y, want);
      run_op({tag, "_sw"}, y, x, want);
   endtask

   initial begin
      logic [31:0] x, y, hold;
      int n;
      #1;
      check("init_done", {31'd0, done}, 32'd0);
      check("init_z", Zout, 32'd0);

      run_pair("pos_diff", 32'h3F4CCCCD, 32'hBF333333, 32'h3DCCCCD0);
      run_pair("neg_diff", 32'hBF4CCCCD, 32'h3F333333, 32'hBDCCCCD0);
      run_pair("sub_sub",  32'h007FFFFF, 32'h00000001, 32'h00800000);
      run_op("min_norm_m1", 32'h00800000, 32'h80000001, 32'h007FFFFF);
      run_op("cross_exp",   32'h00800000, 32'h81000001, 32'h80800002);
      run_op("inf_m_inf",   32'h7F800000, 32'hFF800000, 32'h7FC00000);
      run_op("one_m_one",   32'h3F800000, 32'hBF800000, 32'h00000000);
      run_op("overflow",    32'h7F7FFFFF, 32'h7F7FFFFF, 32'h7F800000);
      run_op("nan_in",      32'h7FC00001, 32'h3F800000, 32'h7FC00000);
      run_op("pz_pz",       32'h00000000, 32'h00000000, 32'h00000000);
      run_op("nz_nz",       32'h80000000, 32'h80000000, 32'h80000000);
      run_op("pz_nz",       32'h00000000, 32'h80000000, 32'h00000000);
      run_op("inf_fin",     32'hFF800000, 32'h42000000, 32'hFF800000);

      for (int i = 0; i < 300; i++) begin
         x = rand_fp($urandom);
         y = rand_fp(x);
         run_op("rand", x, y, ref_add(x, y));
      end

      // Abort partway through, then run a fresh operation and watch it hold.
      @(negedge clk);
      reset = 1'b0;
      Xin = 32'h3F4CCCCD;
      Yin = 32'hBF333333;
      @(negedge clk);
      reset = 1'b1;
      repeat (3) @(posedge clk);
      #2;
      reset = 1'b0;
      #1;
      check("abort_done", {31'd0, done}, 32'd0);
      check("abort_z", Zout, 32'd0);
      check("abort_state", {29'd0, dbg_state}, {29'd0, S_LOAD});
      @(negedge clk);
      Xin = 32'h00800000;
      Yin = 32'h81000001;
      @(negedge clk);
      reset = 1'b1;
      wait_done(n, 1'b0);
      check("abort_relat", n, 32'd7);
      check("abort_rez", Zout, 32'h80800002);
      hold = 32'h80800002;
      for (int i = 0; i < 50; i++) begin
         @(posedge clk);
         Xin = $urandom;
         Yin = $urandom;
         #1;
         check("hold_z", Zout, hold);
         check("hold_done", {31'd0, done}, 32'd1);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
